// File: rtl/mux_sel_pkg.sv
// Shared types and constants for the round-robin mux select controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mux_sel_pkg;

  // GAP is only reachable when the build defines MUX_SEL_GAP_EN.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    GAP   = 2'd3
  } state_e;

  // Mux select encoding: se=0 routes A, se=1 routes B.
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Loadable saturating dwell counter; done when HOLD_CYCLES grant cycles are reached.
// Latency: load/inc take effect at the next clk edge; done is decoded from the register.
// Backpressure: none; inc holds at HOLD_CYCLES instead of wrapping.
// Ports: clk, rst_n (async active-low), load (restart at 1), inc (count one cycle), done.
module dwell_counter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic inc,
  output logic done
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Loading 1 means the first grant cycle is already counted, so a
  // dwell of HOLD_CYCLES cycles ends when the register reads HOLD_CYCLES.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CNT_ONE;
    end else if (inc && (cnt_q < CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q >= CNT_MAX);

endmodule

// File: rtl/mux_rr_select.sv
// Round-robin se/en controller for the 2:1 enable-gated mux; fixed dwell per grant.
// Latency: request sampled at edge k -> grant/en registered high after edge k.
// Backpressure: sources wait while the other owns the mux; owner may release early.
// Ports: clk, rst_n (async active-low), req_a, req_b in; se, en, grant_a, grant_b, sw out.
// Build option MUX_SEL_GAP_EN: one dead cycle (en=0, se already switched) on each source change.
module mux_rr_select
  import mux_sel_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic se,
  output logic en,
  output logic grant_a,
  output logic grant_b,
  output logic sw
);

  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("mux_rr_select: HOLD_CYCLES must be >= 1");
  end

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;             // source favoured on a tie
  logic   last_q, last_d;           // previous owner
  logic   last_vld_q, last_vld_d;   // no owner yet since reset
  logic   se_q, se_d;
  logic   en_q, en_d;
  logic   grant_a_q, grant_a_d;
  logic   grant_b_q, grant_b_d;
  logic   sw_q, sw_d;

  logic   cnt_load, cnt_inc, cnt_done;
  logic   gnt_vld, gnt_sel;
  logic   own_sel, own_req, oth_req;

  dwell_counter #(.HOLD_CYCLES(HOLD_CYCLES)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .inc   (cnt_inc),
    .done  (cnt_done)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    last_d     = last_q;
    last_vld_d = last_vld_q;
    se_d       = se_q;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    gnt_vld    = 1'b0;
    gnt_sel    = SEL_A;
    own_sel    = (state_q == GNT_B) ? SEL_B : SEL_A;
    own_req    = (state_q == GNT_B) ? req_b : req_a;
    oth_req    = (state_q == GNT_B) ? req_a : req_b;

    case (state_q)
      IDLE: begin
        if (req_a && req_b) begin
          gnt_vld = 1'b1;
          gnt_sel = ptr_q;
        end else if (req_a || req_b) begin
          gnt_vld = 1'b1;
          gnt_sel = req_b ? SEL_B : SEL_A;
        end
      end
      GNT_A, GNT_B: begin
        // Re-arbitrate at the end of the dwell or as soon as the owner lets go.
        if (!own_req || cnt_done) begin
          if (oth_req) begin
`ifdef MUX_SEL_GAP_EN
            state_d = GAP;
            se_d    = ~own_sel;   // pre-steer the mux during the dead cycle
`else
            gnt_vld = 1'b1;
            gnt_sel = ~own_sel;
`endif
          end else if (own_req) begin
            gnt_vld = 1'b1;
            gnt_sel = own_sel;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_inc = 1'b1;
        end
      end
`ifdef MUX_SEL_GAP_EN
      GAP: begin
        // se_q already holds the switch target.
        if (se_q ? req_b : req_a) begin
          gnt_vld = 1'b1;
          gnt_sel = se_q;
        end else begin
          state_d = IDLE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    if (gnt_vld) begin
      state_d    = (gnt_sel == SEL_B) ? GNT_B : GNT_A;
      cnt_load   = 1'b1;
      ptr_d      = ~gnt_sel;
      last_d     = gnt_sel;
      last_vld_d = 1'b1;
      se_d       = gnt_sel;
    end

    // Outputs are decoded from the next state so they register with it.
    grant_a_d = (state_d == GNT_A);
    grant_b_d = (state_d == GNT_B);
    en_d      = grant_a_d || grant_b_d;
    sw_d      = gnt_vld && (!last_vld_q || (gnt_sel != last_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= SEL_A;
      last_q     <= SEL_A;
      last_vld_q <= 1'b0;
      se_q       <= 1'b0;
      en_q       <= 1'b0;
      grant_a_q  <= 1'b0;
      grant_b_q  <= 1'b0;
      sw_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
      se_q       <= se_d;
      en_q       <= en_d;
      grant_a_q  <= grant_a_d;
      grant_b_q  <= grant_b_d;
      sw_q       <= sw_d;
    end
  end

  assign se      = se_q;
  assign en      = en_q;
  assign grant_a = grant_a_q;
  assign grant_b = grant_b_q;
  assign sw      = sw_q;

endmodule

// File: tb/tb_mux_rr_select.sv
// Self-checking bench for mux_rr_select with HOLD_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux_rr_select;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0;
  logic req_b = 1'b0;
  logic se, en, grant_a, grant_b, sw;

  int n_checks = 0;
  int n_fail = 0;

  mux_rr_select #(.HOLD_CYCLES(HOLD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a   (req_a),
    .req_b   (req_b),
    .se      (se),
    .en      (en),
    .grant_a (grant_a),
    .grant_b (grant_b),
    .sw      (sw)
  );

  always #5 clk = ~clk;

  // Reference model: owner/target as 0=none, 1=A, 2=B; held = grant cycles so far.
  int m_own, m_held, m_ptr, m_last, m_tgt;
  bit m_gap, m_se, m_sw;

  task automatic model_reset();
    m_own = 0; m_held = 0; m_ptr = 1; m_last = 0; m_tgt = 0;
    m_gap = 0; m_se = 0; m_sw = 0;
  endtask

  task automatic model_step(input bit ra, input bit rb);
    int want;
    int cur;
    bit own_r, oth_r;
    want = 0;
    m_sw = 0;
    if (m_gap) begin
      m_gap = 0;
      if ((m_tgt == 1 && ra) || (m_tgt == 2 && rb)) want = m_tgt;
    end else if (m_own == 0) begin
      if (ra && rb) want = m_ptr;
      else if (ra) want = 1;
      else if (rb) want = 2;
    end else begin
      cur   = m_own;
      own_r = (cur == 1) ? ra : rb;
      oth_r = (cur == 1) ? rb : ra;
      if (own_r && m_held < HOLD) begin
        m_held++;
      end else begin
        m_own = 0;
        if (oth_r) begin
`ifdef MUX_SEL_GAP_EN
          m_gap = 1;
          m_tgt = 3 - cur;
          m_se  = (m_tgt == 2);
`else
          want = 3 - cur;
`endif
        end else if (own_r) begin
          want = cur;
        end
      end
    end
    if (want != 0) begin
      m_sw   = (want != m_last);
      m_own  = want;
      m_held = 1;
      m_ptr  = 3 - want;
      m_last = want;
      m_se   = (want == 2);
    end
  endtask

  // Advance one clock: model samples the same inputs as the DUT, outputs checked 1ns later.
  task automatic step();
    @(posedge clk);
    model_step(req_a, req_b);
    #1;
  endtask

  task automatic do_reset(input bit ra, input bit rb);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_a = ra;
    req_b = rb;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1'b1, 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({grant_a, grant_b, en, se, sw} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 00000", {grant_a, grant_b, en, se, sw});
    end
    #1;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({grant_a, grant_b, en, se, sw} !== 5'b10101) begin
      n_fail++;
      $display("FAIL reset_first_grant: ga,gb,en,se,sw got %b want 10101",
               {grant_a, grant_b, en, se, sw});
    end
  endtask

  task automatic test_single();
    int sw_cnt;
    do_reset(1'b1, 1'b0);
    sw_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      if (sw) sw_cnt++;
      n_checks++;
      if ({en, se, grant_a} !== 3'b101) begin
        n_fail++;
        $display("FAIL single_hold cyc %0d: en,se,ga got %b want 101", i, {en, se, grant_a});
      end
    end
    n_checks++;
    if (sw_cnt !== 1) begin
      n_fail++;
      $display("FAIL single_sw_count: got %0d want 1", sw_cnt);
    end
  endtask

  task automatic test_contention();
    int period, ph, bad;
    bit ea, eb, eon, ese, esw;
`ifdef MUX_SEL_GAP_EN
    period = 10;
`else
    period = 8;
`endif
    bad = 0;
    do_reset(1'b1, 1'b1);
    for (int i = 0; i < 30; i++) begin
      step();
      ph = i % period;
`ifdef MUX_SEL_GAP_EN
      ea  = (ph < 4);
      eb  = (ph >= 5 && ph <= 8);
      ese = (ph >= 4 && ph <= 8);
      esw = (ph == 0 || ph == 5);
`else
      ea  = (ph < 4);
      eb  = (ph >= 4);
      ese = eb;
      esw = (ph == 0 || ph == 4);
`endif
      eon = ea | eb;
      n_checks++;
      if ({grant_a, grant_b, en, se, sw} !== {ea, eb, eon, ese, esw}) begin
        n_fail++;
        bad++;
        $display("FAIL contention cyc %0d: ga,gb,en,se,sw got %b want %b",
                 i, {grant_a, grant_b, en, se, sw}, {ea, eb, eon, ese, esw});
      end
    end
  endtask

  task automatic test_early_release();
    do_reset(1'b0, 1'b0);
    step();
    n_checks++;
    if (en !== 1'b0) begin
      n_fail++;
      $display("FAIL early_idle: en got %b want 0", en);
    end
    req_a = 1'b1;
    step();
    step();
    n_checks++;
    if ({grant_a, en} !== 2'b11) begin
      n_fail++;
      $display("FAIL early_second_cycle: ga,en got %b want 11", {grant_a, en});
    end
    req_a = 1'b0;
    step();
    n_checks++;
    if ({grant_a, grant_b, en} !== 3'b000) begin
      n_fail++;
      $display("FAIL early_release: ga,gb,en got %b want 000", {grant_a, grant_b, en});
    end
    step();
    n_checks++;
    if ({grant_a, grant_b, en, sw} !== 4'b0000) begin
      n_fail++;
      $display("FAIL early_stays_idle: ga,gb,en,sw got %b want 0000",
               {grant_a, grant_b, en, sw});
    end
  endtask

  task automatic test_async_reset();
    int waited;
    do_reset(1'b1, 1'b1);
    waited = 0;
    step();
    while (!grant_b && waited < 20) begin
      step();
      waited++;
    end
    n_checks++;
    if (grant_b !== 1'b1) begin
      n_fail++;
      $display("FAIL async_wait_b: grant_b got %b want 1 within 20 cycles", grant_b);
    end
    step();
    step();
    n_checks++;
    if ({grant_b, se, en} !== 3'b111) begin
      n_fail++;
      $display("FAIL async_third_b: gb,se,en got %b want 111", {grant_b, se, en});
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({grant_a, grant_b, en, se, sw} !== 5'b0) begin
      n_fail++;
      $display("FAIL async_clear: outputs got %b want 00000 before next edge",
               {grant_a, grant_b, en, se, sw});
    end
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    n_checks++;
    if ({grant_a, grant_b, se, en} !== 4'b1001) begin
      n_fail++;
      $display("FAIL async_restart_a: ga,gb,se,en got %b want 1001",
               {grant_a, grant_b, se, en});
    end
  endtask

  task automatic test_random();
    bit [4:0] exp;
    do_reset(1'b0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      step();
      exp = {m_own == 1, m_own == 2, m_own != 0, m_se, m_sw};
      n_checks++;
      if ({grant_a, grant_b, en, se, sw} !== exp) begin
        n_fail++;
        $display("FAIL random cyc %0d: ga,gb,en,se,sw got %b want %b",
                 i, {grant_a, grant_b, en, se, sw}, exp);
      end
      n_checks++;
      if ((grant_a && grant_b) || (en !== (grant_a | grant_b)) || (grant_b && !se)) begin
        n_fail++;
        $display("FAIL random_invariant cyc %0d: ga,gb,en,se got %b",
                 i, {grant_a, grant_b, en, se});
      end
      if ($urandom_range(0, 5) == 0) req_a = ~req_a;
      if ($urandom_range(0, 5) == 0) req_b = ~req_b;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
